// File: rtl/bram_pingpong_writer.sv
// Ping-pong BRAM writer: absorbs the upstream word stream into two banks of
// BANK_DEPTH words, flags full banks and refills them once the consumer releases them.
module bram_pingpong_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [DATA_WIDTH-1:0] DIN_DATA,
    input  logic                  DIN_VALID,
    output logic                  DIN_ACCEP,
    output logic                  BRAM_EN,
    output logic                  BRAM_WE,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
    output logic [DATA_WIDTH-1:0] BRAM_DIN,
    output logic [1:0]            BANK_FULL,
    input  logic [1:0]            BANK_RELEASE,
    output logic                  ACTIVE_BANK,
    output logic [ADDR_WIDTH-1:0] FILL_COUNT,
    output logic                  OVERFLOW
);

    localparam int BANK_DEPTH = 2 ** (ADDR_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(BANK_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(BANK_DEPTH - 1);

    typedef enum logic {
        FILL = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                  state_q;
    logic                    activeBank_q;
    logic [ADDR_WIDTH-1:0]   fillCount_q;
    logic [1:0]              bankFull_q;
    logic [1:0]              bankFull_d;
    logic                    overflow_q;
    logic                    bramEn_q;
    logic                    bramWe_q;
    logic [ADDR_WIDTH-1:0]   bramAddr_q;
    logic [DATA_WIDTH-1:0]   bramDin_q;

    logic inFill;
    logic writeFire;
    logic lastWrite;
    logic dropWord;
    logic otherFree;

    always_comb begin
        inFill    = (state_q == FILL);
        writeFire = inFill && DIN_VALID;
        lastWrite = writeFire && (fillCount_q == LAST_IDX);
        dropWord  = DIN_VALID && !writeFire;
        otherFree = !bankFull_q[~activeBank_q] || BANK_RELEASE[~activeBank_q];
        // A completing write on a bank beats a release of that same bank.
        bankFull_d = 2'b00;
        for (int b = 0; b < 2; b++) begin
            bankFull_d[b] = (lastWrite && (activeBank_q == 1'(b)))
                         || (bankFull_q[b] && !BANK_RELEASE[b]);
        end
    end

    assign DIN_ACCEP = inFill && !ARESET
                    && (({1'b0, fillCount_q} + {{ADDR_WIDTH{1'b0}}, DIN_VALID}) < DEPTH_EXT);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= FILL;
            activeBank_q <= 1'b0;
            fillCount_q  <= '0;
            bankFull_q   <= 2'b00;
            overflow_q   <= 1'b0;
            bramEn_q     <= 1'b0;
            bramWe_q     <= 1'b0;
            bramAddr_q   <= '0;
            bramDin_q    <= '0;
        end else begin
            bramEn_q   <= writeFire;
            bramWe_q   <= writeFire;
            bankFull_q <= bankFull_d;
            if (writeFire) begin
                bramAddr_q <= {activeBank_q, fillCount_q[ADDR_WIDTH-2:0]};
                bramDin_q  <= DIN_DATA;
            end
            if (dropWord) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                FILL: begin
                    if (lastWrite) begin
                        fillCount_q  <= '0;
                        activeBank_q <= ~activeBank_q;
                        // The bank now pointed at is still unread: park until it is freed.
                        if (!otherFree) begin
                            state_q <= WAIT;
                        end
                    end else if (writeFire) begin
                        fillCount_q <= fillCount_q + 1'b1;
                    end
                end
                WAIT: begin
                    if (BANK_RELEASE[activeBank_q]) begin
                        state_q <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign BRAM_EN     = bramEn_q;
    assign BRAM_WE     = bramWe_q;
    assign BRAM_ADDR   = bramAddr_q;
    assign BRAM_DIN    = bramDin_q;
    assign BANK_FULL   = bankFull_q;
    assign ACTIVE_BANK = activeBank_q;
    assign FILL_COUNT  = fillCount_q;
    assign OVERFLOW    = overflow_q;

endmodule
